// File: rtl/uart_imem_loader.sv
// uart_imem_loader
//   UART receiver that packs received bytes little-endian into memory words
//   and writes them to consecutive addresses of an instruction memory.
//   Loading stops when an all-ones word arrives or the last address is written.
// Ports:
//   sys_clk     : single system clock, rising edge
//   rst_n       : asynchronous active-low reset
//   rx_serial   : UART line (idle high), asynchronous to sys_clk
//   byte_valid  : one-cycle pulse per accepted byte
//   byte_data   : last accepted byte, zero-extended above DATA_BITS
//   imem_we     : one-cycle memory write strobe
//   imem_addr   : word address of the current write
//   imem_wdata  : assembled word
//   frame_err   : sticky, a stop bit was sampled low
//   parity_err  : sticky, a parity mismatch was seen
//   busy        : receiver FSM is not idle
//   load_done   : sticky, halt word seen or memory full
module uart_imem_loader #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int WORD_BYTES = 4,
  parameter int ADDR_W     = 10
) (
  input  logic                    sys_clk,
  input  logic                    rst_n,
  input  logic                    rx_serial,
  output logic                    byte_valid,
  output logic [7:0]              byte_data,
  output logic                    imem_we,
  output logic [ADDR_W-1:0]       imem_addr,
  output logic [8*WORD_BYTES-1:0] imem_wdata,
  output logic                    frame_err,
  output logic                    parity_err,
  output logic                    busy,
  output logic                    load_done
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CNT_W  = $clog2(CLKS_PER_BIT + 1);
  localparam int IDX_W  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int WORD_W = 8 * WORD_BYTES;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_HALF = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [3:0]        BIT_LAST = 4'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(WORD_BYTES - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
  localparam logic              ODD_MODE = (PARITY == 2);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // Even mode wants XOR(data, parity bit) = 0, odd mode wants 1.
  function automatic logic parity_fail(input logic [DATA_BITS-1:0] data, input logic pbit);
    return ((^data) ^ pbit) != ODD_MODE;
  endfunction

  state_t               state_r, state_next_s;
  logic                 sync1_r, sync2_r, line_s;
  logic [CNT_W-1:0]     cnt_r;
  logic [3:0]           bit_cnt_r;
  logic [DATA_BITS-1:0] shift_r;
  logic                 bad_r;
  logic [IDX_W-1:0]     byte_idx_r;
  logic                 cnt_clear_s, take_data_s, take_par_s, take_stop_s;
  logic                 good_s, word_full_s, halt_s;
  logic [7:0]           byte_s;
  logic [WORD_W-1:0]    word_next_s;
  logic                 byte_valid_r, imem_we_r, frame_err_r, parity_err_r, busy_r, load_done_r;
  logic [7:0]           byte_data_r;
  logic [ADDR_W-1:0]    imem_addr_r;
  logic [WORD_W-1:0]    imem_wdata_r;

  assign line_s = sync2_r;

  // Two-flop synchronizer for the asynchronous serial line (idles high).
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= rx_serial;
      sync2_r <= sync1_r;
    end
  end

  // FSM state register.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next state and sample strobes. START checks mid-start-bit, then the
  // counter restarts so each full count lands in the middle of the next bit.
  always_comb begin
    state_next_s = state_r;
    cnt_clear_s  = 1'b0;
    take_data_s  = 1'b0;
    take_par_s   = 1'b0;
    take_stop_s  = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (!line_s) begin
          state_next_s = S_START;
          cnt_clear_s  = 1'b1;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_START: begin
        if (cnt_r == CNT_HALF) begin
          cnt_clear_s  = 1'b1;
          state_next_s = line_s ? S_IDLE : S_DATA;
        end else begin
          state_next_s = S_START;
        end
      end
      S_DATA: begin
        if (cnt_r == CNT_LAST) begin
          take_data_s = 1'b1;
          if (bit_cnt_r == BIT_LAST) begin
            state_next_s = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            state_next_s = S_DATA;
          end
        end else begin
          state_next_s = S_DATA;
        end
      end
      S_PARITY: begin
        if (cnt_r == CNT_LAST) begin
          take_par_s   = 1'b1;
          state_next_s = S_STOP;
        end else begin
          state_next_s = S_PARITY;
        end
      end
      S_STOP: begin
        if (cnt_r == CNT_LAST) begin
          take_stop_s  = 1'b1;
          state_next_s = S_IDLE;
        end else begin
          state_next_s = S_STOP;
        end
      end
      default: begin
        state_next_s = S_IDLE;
        cnt_clear_s  = 1'b1;
      end
    endcase
  end

  // Bit timing counter, data shift register and per-byte bad marker.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r     <= {CNT_W{1'b0}};
      bit_cnt_r <= 4'd0;
      shift_r   <= {DATA_BITS{1'b0}};
      bad_r     <= 1'b0;
    end else begin
      if (cnt_clear_s || state_r == S_IDLE || cnt_r == CNT_LAST) begin
        cnt_r <= {CNT_W{1'b0}};
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
      if (state_r == S_IDLE) begin
        bit_cnt_r <= 4'd0;
        bad_r     <= 1'b0;
      end else if (take_data_s) begin
        shift_r   <= {line_s, shift_r[DATA_BITS-1:1]};
        bit_cnt_r <= bit_cnt_r + 4'd1;
      end else if (take_par_s && parity_fail(shift_r, line_s)) begin
        bad_r <= 1'b1;
      end
    end
  end

  // Byte acceptance and slot insertion into the word under construction.
  always_comb begin
    good_s      = take_stop_s && line_s && !bad_r;
    byte_s      = 8'(shift_r);
    word_next_s = imem_wdata_r;
    for (int k = 0; k < WORD_BYTES; k++) begin
      if (byte_idx_r == IDX_W'(k)) begin
        word_next_s[8*k +: 8] = byte_s;
      end else begin
        word_next_s[8*k +: 8] = imem_wdata_r[8*k +: 8];
      end
    end
    word_full_s = (byte_idx_r == IDX_LAST);
    halt_s      = (word_next_s == {WORD_W{1'b1}});
  end

  // Output strobes, sticky flags, word assembly and address advance.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_valid_r <= 1'b0;
      byte_data_r  <= 8'd0;
      imem_we_r    <= 1'b0;
      imem_addr_r  <= {ADDR_W{1'b0}};
      imem_wdata_r <= {WORD_W{1'b0}};
      byte_idx_r   <= {IDX_W{1'b0}};
      frame_err_r  <= 1'b0;
      parity_err_r <= 1'b0;
      busy_r       <= 1'b0;
      load_done_r  <= 1'b0;
    end else begin
      byte_valid_r <= good_s;
      imem_we_r    <= 1'b0;
      busy_r       <= (state_next_s != S_IDLE);
      if (good_s) begin
        byte_data_r <= byte_s;
      end
      if (take_stop_s && !line_s) begin
        frame_err_r <= 1'b1;
      end
      if (take_par_s && parity_fail(shift_r, line_s)) begin
        parity_err_r <= 1'b1;
      end
      if (good_s && !load_done_r) begin
        imem_wdata_r <= word_next_s;
        if (word_full_s) begin
          byte_idx_r <= {IDX_W{1'b0}};
          if (halt_s) begin
            load_done_r <= 1'b1;
          end else begin
            imem_we_r <= 1'b1;
          end
        end else begin
          byte_idx_r <= byte_idx_r + IDX_W'(1);
        end
      end
      // The write at the last address completes; the address then stays put.
      if (imem_we_r) begin
        if (imem_addr_r == ADDR_LAST) begin
          load_done_r <= 1'b1;
        end else begin
          imem_addr_r <= imem_addr_r + ADDR_W'(1);
        end
      end
    end
  end

  assign byte_valid = byte_valid_r;
  assign byte_data  = byte_data_r;
  assign imem_we    = imem_we_r;
  assign imem_addr  = imem_addr_r;
  assign imem_wdata = imem_wdata_r;
  assign frame_err  = frame_err_r;
  assign parity_err = parity_err_r;
  assign busy       = busy_r;
  assign load_done  = load_done_r;

endmodule

// File: tb/tb_uart_imem_loader.sv
// tb_uart_imem_loader
//   Three loader instances sharing one clock: A (defaults, 8N1, 4-byte words),
//   B (even parity) and C (1-byte words, 2-bit address). The bit rate is
//   raised to 64 clocks per bit so that many frames fit in a short run.
module tb_uart_imem_loader;
  localparam int CPB      = 64;
  localparam int CLK_FREQ = 100_000_000;
  localparam int BAUD     = CLK_FREQ / CPB;

  logic sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic rst_a, rx_a, bv_a, we_a, fe_a, pe_a, busy_a, done_a;
  logic [7:0] bd_a; logic [9:0] addr_a; logic [31:0] wd_a;
  logic rst_b, rx_b, bv_b, we_b, fe_b, pe_b, busy_b, done_b;
  logic [7:0] bd_b; logic [9:0] addr_b; logic [31:0] wd_b;
  logic rst_c, rx_c, bv_c, we_c, fe_c, pe_c, busy_c, done_c;
  logic [7:0] bd_c; logic [1:0] addr_c; logic [7:0] wd_c;

  uart_imem_loader #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut_a (
    .sys_clk(sys_clk), .rst_n(rst_a), .rx_serial(rx_a), .byte_valid(bv_a), .byte_data(bd_a),
    .imem_we(we_a), .imem_addr(addr_a), .imem_wdata(wd_a), .frame_err(fe_a),
    .parity_err(pe_a), .busy(busy_a), .load_done(done_a));
  uart_imem_loader #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .PARITY(1)) dut_b (
    .sys_clk(sys_clk), .rst_n(rst_b), .rx_serial(rx_b), .byte_valid(bv_b), .byte_data(bd_b),
    .imem_we(we_b), .imem_addr(addr_b), .imem_wdata(wd_b), .frame_err(fe_b),
    .parity_err(pe_b), .busy(busy_b), .load_done(done_b));
  uart_imem_loader #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .WORD_BYTES(1), .ADDR_W(2)) dut_c (
    .sys_clk(sys_clk), .rst_n(rst_c), .rx_serial(rx_c), .byte_valid(bv_c), .byte_data(bd_c),
    .imem_we(we_c), .imem_addr(addr_c), .imem_wdata(wd_c), .frame_err(fe_c),
    .parity_err(pe_c), .busy(busy_c), .load_done(done_c));

  int checks = 0;
  int errors = 0;

  // Observed events: {dut, byte} and {dut, addr, wdata}.
  logic [15:0] got_bv[$];
  logic [71:0] got_we[$];
  logic [15:0] exp_bv[$];
  logic [71:0] exp_we[$];

  always @(negedge sys_clk) begin
    if (bv_a) got_bv.push_back({8'd0, bd_a});
    if (bv_b) got_bv.push_back({8'd1, bd_b});
    if (bv_c) got_bv.push_back({8'd2, bd_c});
    if (we_a) got_we.push_back({8'd0, 32'(addr_a), wd_a});
    if (we_b) got_we.push_back({8'd1, 32'(addr_b), wd_b});
    if (we_c) got_we.push_back({8'd2, 32'(addr_c), 32'(wd_c)});
  end

  // Reference model: per-instance loader state in plain arithmetic.
  int          m_wb[3]  = '{4, 4, 1};
  int          m_aw[3]  = '{10, 10, 2};
  int          m_par[3] = '{0, 1, 0};
  int          m_idx[3];
  logic [31:0] m_addr[3], m_word[3];
  logic        m_done[3], m_fe[3], m_pe[3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic model_reset(input int d);
    m_idx[d] = 0; m_addr[d] = 32'd0; m_word[d] = 32'd0;
    m_done[d] = 1'b0; m_fe[d] = 1'b0; m_pe[d] = 1'b0;
  endtask

  task automatic model_frame(input int d, input logic [7:0] data, input logic pbit, input logic stop);
    logic good;
    logic [31:0] full;
    good = stop;
    if (!stop) m_fe[d] = 1'b1;
    if (m_par[d] != 0 && (((^data) ^ pbit) != (m_par[d] == 2))) begin
      m_pe[d] = 1'b1;
      good = 1'b0;
    end
    if (good) begin
      exp_bv.push_back({8'(d), data});
      if (!m_done[d]) begin
        if (m_idx[d] == 0) m_word[d] = 32'd0;
        m_word[d] = m_word[d] | (32'(data) << (8 * m_idx[d]));
        m_idx[d]++;
        if (m_idx[d] == m_wb[d]) begin
          m_idx[d] = 0;
          full = (m_wb[d] == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * m_wb[d])) - 32'd1);
          if (m_word[d] == full) begin
            m_done[d] = 1'b1;
          end else begin
            exp_we.push_back({8'(d), m_addr[d], m_word[d]});
            if (m_addr[d] == (32'd1 << m_aw[d]) - 32'd1) m_done[d] = 1'b1;
            else m_addr[d] = m_addr[d] + 32'd1;
          end
        end
      end
    end
  endtask

  // sel: 0 frame_err, 1 parity_err, 2 load_done, 3 imem_addr, 4 busy, 5 byte_data
  function automatic logic [31:0] obs(input int d, input int sel);
    logic [31:0] v[6];
    case (d)
      0: v = '{32'(fe_a), 32'(pe_a), 32'(done_a), 32'(addr_a), 32'(busy_a), 32'(bd_a)};
      1: v = '{32'(fe_b), 32'(pe_b), 32'(done_b), 32'(addr_b), 32'(busy_b), 32'(bd_b)};
      default: v = '{32'(fe_c), 32'(pe_c), 32'(done_c), 32'(addr_c), 32'(busy_c), 32'(bd_c)};
    endcase
    return v[sel];
  endfunction

  task automatic set_line(input int d, input logic v);
    case (d)
      0: rx_a = v;
      1: rx_b = v;
      default: rx_c = v;
    endcase
  endtask

  task automatic hold(input int d, input logic v, input int n);
    set_line(d, v);
    repeat (n) @(negedge sys_clk);
  endtask

  // Low stop bit is held only 3/4 of a bit so the tail reads as a false start.
  task automatic send_frame(input int d, input logic [7:0] data, input logic pbit, input logic stop);
    hold(d, 1'b0, CPB);
    for (int i = 0; i < 8; i++) hold(d, data[i], CPB);
    if (m_par[d] != 0) hold(d, pbit, CPB);
    if (stop) hold(d, 1'b1, CPB);
    else begin hold(d, 1'b0, 48); hold(d, 1'b1, 16); end
    hold(d, 1'b1, 16);
  endtask

  task automatic do_reset(input int d);
    set_line(d, 1'b1);
    @(negedge sys_clk);
    case (d) 0: rst_a = 1'b0; 1: rst_b = 1'b0; default: rst_c = 1'b0; endcase
    repeat (3) @(negedge sys_clk);
    case (d) 0: rst_a = 1'b1; 1: rst_b = 1'b1; default: rst_c = 1'b1; endcase
    repeat (3) @(negedge sys_clk);
    model_reset(d);
  endtask

  task automatic compare_events(input int d, input string tag);
    chk({tag, " byte_valid count"}, got_bv.size(), exp_bv.size());
    for (int i = 0; i < got_bv.size() && i < exp_bv.size(); i++)
      chk({tag, " byte"}, 32'(got_bv[i]), 32'(exp_bv[i]));
    chk({tag, " imem_we count"}, got_we.size(), exp_we.size());
    for (int i = 0; i < got_we.size() && i < exp_we.size(); i++) begin
      chk({tag, " write addr"}, got_we[i][63:32], exp_we[i][63:32]);
      chk({tag, " write data"}, got_we[i][31:0], exp_we[i][31:0]);
      chk({tag, " write dut"}, 32'(got_we[i][71:64]), 32'(exp_we[i][71:64]));
    end
    chk({tag, " frame_err"}, obs(d, 0), 32'(m_fe[d]));
    chk({tag, " parity_err"}, obs(d, 1), 32'(m_pe[d]));
    chk({tag, " load_done"}, obs(d, 2), 32'(m_done[d]));
    chk({tag, " imem_addr"}, obs(d, 3), m_addr[d]);
    chk({tag, " busy"}, obs(d, 4), 32'd0);
    got_bv.delete(); got_we.delete(); exp_bv.delete(); exp_we.delete();
  endtask

  typedef struct {
    logic        rst;
    logic [7:0]  data;
    logic        stop;
    logic        exp_bv;
    logic        exp_we;
    logic [31:0] exp_wdata;
    logic [31:0] addr_after;
    logic        exp_done;
    logic        exp_fe;
  } vec_t;

  vec_t        tbl[14];
  logic [7:0]  last_good;
  logic [7:0]  rdata;
  logic        rstop, rpbit;

  initial begin
    // Instance A: bad stop bit, two program words, halt word, post-halt byte.
    tbl[0]  = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 32'h0,         32'd0, 1'b0, 1'b1};
    tbl[1]  = '{1'b0, 8'h93, 1'b1, 1'b1, 1'b0, 32'h0,         32'd0, 1'b0, 1'b1};
    tbl[2]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 32'h0,         32'd0, 1'b0, 1'b1};
    tbl[3]  = '{1'b0, 8'h10, 1'b1, 1'b1, 1'b0, 32'h0,         32'd0, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 32'h0010_0093, 32'd1, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, 8'h13, 1'b1, 1'b1, 1'b0, 32'h0,         32'd0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 8'h01, 1'b1, 1'b1, 1'b0, 32'h0,         32'd0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 8'h20, 1'b1, 1'b1, 1'b0, 32'h0,         32'd0, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 32'h0020_0113, 32'd1, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 8'hFF, 1'b1, 1'b1, 1'b0, 32'h0,         32'd1, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 8'hFF, 1'b1, 1'b1, 1'b0, 32'h0,         32'd1, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 8'hFF, 1'b1, 1'b1, 1'b0, 32'h0,         32'd1, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 8'hFF, 1'b1, 1'b1, 1'b0, 32'h0,         32'd1, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 8'h42, 1'b1, 1'b1, 1'b0, 32'h0,         32'd1, 1'b1, 1'b0};

    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    rx_a = 1'b1; rx_b = 1'b1; rx_c = 1'b1;
    for (int d = 0; d < 3; d++) model_reset(d);
    repeat (4) @(negedge sys_clk);
    chk("reset byte_valid", 32'(bv_a), 32'd0);
    chk("reset imem_we", 32'(we_a), 32'd0);
    chk("reset imem_wdata", wd_a, 32'd0);
    chk("reset busy", obs(0, 4), 32'd0);
    chk("reset addr", obs(0, 3), 32'd0);
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    repeat (4) @(negedge sys_clk);

    // Table-driven vectors on instance A.
    last_good = 8'h00;
    for (int i = 0; i < 14; i++) begin
      if (tbl[i].rst) begin do_reset(0); last_good = 8'h00; end
      got_bv.delete(); got_we.delete();
      send_frame(0, tbl[i].data, 1'b0, tbl[i].stop);
      if (tbl[i].exp_bv) last_good = tbl[i].data;
      chk($sformatf("vec%0d byte_valid count", i), got_bv.size(), 32'(tbl[i].exp_bv));
      chk($sformatf("vec%0d byte_data", i), obs(0, 5), 32'(last_good));
      chk($sformatf("vec%0d imem_we count", i), got_we.size(), 32'(tbl[i].exp_we));
      if (tbl[i].exp_we && got_we.size() > 0) begin
        chk($sformatf("vec%0d write addr", i), got_we[0][63:32], 32'd0);
        chk($sformatf("vec%0d write data", i), got_we[0][31:0], tbl[i].exp_wdata);
      end
      chk($sformatf("vec%0d addr after", i), obs(0, 3), tbl[i].addr_after);
      chk($sformatf("vec%0d load_done", i), obs(0, 2), 32'(tbl[i].exp_done));
      chk($sformatf("vec%0d frame_err", i), obs(0, 0), 32'(tbl[i].exp_fe));
      chk($sformatf("vec%0d busy", i), obs(0, 4), 32'd0);
    end
    got_bv.delete(); got_we.delete();

    // 300 ns glitch on the idle line of A: false start, nothing else.
    do_reset(0);
    hold(0, 1'b0, 10);
    chk("glitch busy during", obs(0, 4), 32'd1);
    hold(0, 1'b0, 20);
    hold(0, 1'b1, 60);
    compare_events(0, "glitch");

    // Randomized frames on A checked against the model.
    for (int i = 0; i < 12; i++) begin
      rdata = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      rstop = ($urandom_range(0, 7) != 0);
      send_frame(0, rdata, 1'b0, rstop);
      model_frame(0, rdata, 1'b0, rstop);
      compare_events(0, $sformatf("randA%0d", i));
    end

    // Instance B, even parity: wrong parity bit drops the byte, right one passes.
    do_reset(1);
    send_frame(1, 8'h03, 1'b1, 1'b1);
    model_frame(1, 8'h03, 1'b1, 1'b1);
    chk("parity bad parity_err", obs(1, 1), 32'd1);
    compare_events(1, "parity bad");
    send_frame(1, 8'h03, 1'b0, 1'b1);
    model_frame(1, 8'h03, 1'b0, 1'b1);
    chk("parity good byte_data", obs(1, 5), 32'h03);
    compare_events(1, "parity good");
    for (int i = 0; i < 10; i++) begin
      rdata = 8'($urandom);
      rpbit = (^rdata) ^ ($urandom_range(0, 3) == 0);
      rstop = ($urandom_range(0, 7) != 0);
      send_frame(1, rdata, rpbit, rstop);
      model_frame(1, rdata, rpbit, rstop);
      compare_events(1, $sformatf("randB%0d", i));
    end

    // Instance C: 4-word memory fills, then the 5th byte is only reported.
    do_reset(2);
    for (int i = 0; i < 5; i++) begin
      rdata = 8'(8'h11 * (i + 1));
      send_frame(2, rdata, 1'b0, 1'b1);
      model_frame(2, rdata, 1'b0, 1'b1);
      if (i == 3) chk("full load_done after 4th", obs(2, 2), 32'd1);
      compare_events(2, $sformatf("fill%0d", i));
    end

    // Asynchronous reset in the middle of a frame.
    hold(2, 1'b0, 100);
    #2 rst_c = 1'b0;
    #1;
    chk("midreset busy", obs(2, 4), 32'd0);
    chk("midreset addr", obs(2, 3), 32'd0);
    chk("midreset load_done", obs(2, 2), 32'd0);
    chk("midreset byte_data", obs(2, 5), 32'd0);
    chk("midreset wdata", 32'(wd_c), 32'd0);
    chk("midreset strobes", {30'd0, bv_c, we_c}, 32'd0);
    rx_c = 1'b1;
    repeat (3) @(negedge sys_clk);
    rst_c = 1'b1;
    model_reset(2);
    repeat (20) @(negedge sys_clk);
    got_bv.delete(); got_we.delete();
    send_frame(2, 8'hA5, 1'b0, 1'b1);
    model_frame(2, 8'hA5, 1'b0, 1'b1);
    compare_events(2, "after reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
